// File: rtl/gate_bank_pkg.sv
// Shared encodings and the bitwise gate function for the gate bank.
// Optional parity output is enabled by GATE_BANK_PIPE_PARITY_EN.
package gate_bank_pkg;

    localparam logic [2:0] FN_OR   = 3'd0;
    localparam logic [2:0] FN_AND  = 3'd1;
    localparam logic [2:0] FN_NOR  = 3'd2;
    localparam logic [2:0] FN_NAND = 3'd3;
    localparam logic [2:0] FN_XOR  = 3'd4;
    localparam logic [2:0] FN_XNOR = 3'd5;
    localparam logic [2:0] FN_BUFA = 3'd6;
    localparam logic [2:0] FN_NOTA = 3'd7;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    // Widest bank supported; callers zero-extend and slice.
    localparam int GB_MAX_W = 64;

    typedef logic [GB_MAX_W-1:0] gb_word_t;

    function automatic gb_word_t gate_eval(
        input logic [2:0] func,
        input gb_word_t   a,
        input gb_word_t   b
    );
        gb_word_t r;
        r = '0;
        unique case (func)
            FN_OR:   r = a | b;
            FN_AND:  r = a & b;
            FN_NOR:  r = ~(a | b);
            FN_NAND: r = ~(a & b);
            FN_XOR:  r = a ^ b;
            FN_XNOR: r = ~(a ^ b);
            FN_BUFA: r = a;
            FN_NOTA: r = ~a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gate_bank_pipe_stage.sv
// One pipeline register: data plus valid, with sync reset and valid clear.
// Data only loads on a valid beat so the tail holds the last result.
module gate_bank_pipe_stage #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    logic load;
    assign load = in_valid & ~clr;

    // Advance valid every cycle; capture data only on a live beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= load;
            if (load) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/gate_bank_pipe.sv
// CHANNELS 2-input gates with run-time function select behind a DEPTH pipeline.
// Define GATE_BANK_PIPE_PARITY_EN to add the registered Y_PAR output.
module gate_bank_pipe
    import gate_bank_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 2
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [CHANNELS-1:0] A,
    input  logic [CHANNELS-1:0] B,
    input  logic [2:0]          FUNC,
    input  logic                IN_VALID,
    output logic [CHANNELS-1:0] Y,
    output logic                Y_VALID,
`ifdef GATE_BANK_PIPE_PARITY_EN
    output logic                Y_PAR,
`endif
    output logic                BUSY
);

`ifdef GATE_BANK_PIPE_PARITY_EN
    localparam int W = CHANNELS + 1;
`else
    localparam int W = CHANNELS;
`endif
    localparam int CW = $clog2(DEPTH + 1);

    logic [0:0]          state_q;
    logic [2:0]          fn_q;
    logic [CW-1:0]       cnt_q;
    logic                fn_chg;
    logic                flush_start;
    logic                accept;
    gb_word_t            ev_full;
    logic                ev_unused;
    logic [CHANNELS-1:0] res;
    logic [W-1:0]        sd [DEPTH+1];
    logic                sv [DEPTH+1];

    assign fn_chg      = (FUNC != fn_q);
    assign flush_start = (state_q == ST_RUN) && fn_chg;
    assign accept      = (state_q == ST_RUN) && !fn_chg && IN_VALID;
    assign BUSY        = (state_q == ST_FLUSH);

    assign ev_full   = gate_eval(fn_q, gb_word_t'(A), gb_word_t'(B));
    assign ev_unused = ^ev_full;
    assign res       = ev_full[CHANNELS-1:0];

`ifdef GATE_BANK_PIPE_PARITY_EN
    assign sd[0] = {^res, res};
    assign Y_PAR = sd[DEPTH][CHANNELS];
`else
    assign sd[0] = res;
`endif
    assign sv[0] = accept;

    // Function latch and flush sequencing; any FUNC change restarts the flush.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_RUN;
            fn_q    <= FN_OR;
            cnt_q   <= '0;
        end else if (fn_chg) begin
            state_q <= ST_FLUSH;
            fn_q    <= FUNC;
            cnt_q   <= CW'(DEPTH);
        end else if (state_q == ST_FLUSH) begin
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                state_q <= ST_RUN;
            end
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        gate_bank_pipe_stage #(
            .W(W)
        ) u_stage (
            .clk      (CLK),
            .rst      (RST),
            .clr      (flush_start),
            .in_valid (sv[i]),
            .in_data  (sd[i]),
            .out_valid(sv[i+1]),
            .out_data (sd[i+1])
        );
    end

    assign Y       = sd[DEPTH][CHANNELS-1:0];
    assign Y_VALID = sv[DEPTH];

endmodule

// File: tb/tb_gate_bank_pipe.sv
// Self-checking bench for gate_bank_pipe (CHANNELS=4, DEPTH=2).
// Checks parity too when GATE_BANK_PIPE_PARITY_EN is defined.
module tb_gate_bank_pipe;

    localparam int CH = 4;
    localparam int DP = 2;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [CH-1:0] A = '0;
    logic [CH-1:0] B = '0;
    logic [2:0]    FUNC = 3'd0;
    logic          IN_VALID = 1'b0;
    logic [CH-1:0] Y;
    logic          Y_VALID;
    logic          BUSY;
`ifdef GATE_BANK_PIPE_PARITY_EN
    logic          Y_PAR;
`endif

    gate_bank_pipe #(
        .CHANNELS(CH),
        .DEPTH   (DP)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .A       (A),
        .B       (B),
        .FUNC    (FUNC),
        .IN_VALID(IN_VALID),
        .Y       (Y),
        .Y_VALID (Y_VALID),
`ifdef GATE_BANK_PIPE_PARITY_EN
        .Y_PAR   (Y_PAR),
`endif
        .BUSY    (BUSY)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int         due;
        logic [3:0] val;
    } res_t;

    res_t       q[$];
    int         cyc = 0;
    logic [2:0] m_fn = 3'd0;
    int         m_busy = 0;
    logic [3:0] m_y = 4'd0;
    logic       m_v = 1'b0;

    logic [3:0] tbl_y [8] = '{4'b1110, 4'b1000, 4'b0001, 4'b0111,
                              4'b0110, 4'b1001, 4'b1100, 4'b0011};
    logic [2:0] tbl_f [8] = '{3'd1, 3'd2, 3'd3, 3'd4,
                              3'd5, 3'd6, 3'd7, 3'd0};

    function automatic logic [3:0] ref_gate(input logic [2:0] f,
                                            input logic [3:0] a,
                                            input logic [3:0] b);
        case (f)
            3'd0: return a | b;
            3'd1: return a & b;
            3'd2: return ~(a | b);
            3'd3: return ~(a & b);
            3'd4: return a ^ b;
            3'd5: return ~(a ^ b);
            3'd6: return a;
            default: return ~a;
        endcase
    endfunction

    task automatic check(input string tag, input logic [3:0] obs,
                         input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Reference: results are scheduled for the edge DEPTH-1 after sampling;
    // a function change empties the schedule and blocks input for DEPTH edges.
    task automatic model_edge(input logic [3:0] a, input logic [3:0] b,
                              input logic [2:0] f, input logic iv,
                              input logic r);
        res_t e;
        cyc++;
        if (r) begin
            q.delete();
            m_fn   = 3'd0;
            m_busy = 0;
            m_y    = 4'd0;
            m_v    = 1'b0;
        end else begin
            if (f != m_fn) begin
                m_fn   = f;
                m_busy = DP;
                q.delete();
            end else if (m_busy > 0) begin
                m_busy--;
            end else if (iv) begin
                e.due = cyc + DP - 1;
                e.val = ref_gate(m_fn, a, b);
                q.push_back(e);
            end
            m_v = 1'b0;
            if (q.size() > 0 && q[0].due == cyc) begin
                m_y = q[0].val;
                m_v = 1'b1;
                void'(q.pop_front());
            end
        end
    endtask

    task automatic step(input string tag, input logic [3:0] a,
                        input logic [3:0] b, input logic [2:0] f,
                        input logic iv, input logic r);
        @(negedge CLK);
        A        = a;
        B        = b;
        FUNC     = f;
        IN_VALID = iv;
        RST      = r;
        @(posedge CLK);
        #1;
        model_edge(a, b, f, iv, r);
        check({tag, "_y"}, Y, m_y);
        check({tag, "_v"}, {3'b0, Y_VALID}, {3'b0, m_v});
        check({tag, "_busy"}, {3'b0, BUSY}, {3'b0, (m_busy > 0)});
`ifdef GATE_BANK_PIPE_PARITY_EN
        check({tag, "_par"}, {3'b0, Y_PAR}, {3'b0, ^m_y});
`endif
    endtask

    initial begin
        logic [2:0] cf;

        // Reset state
        step("rst", 4'b0, 4'b0, 3'd0, 1'b0, 1'b1);
        check("rst_y0", Y, 4'b0000);
        check("rst_busy0", {3'b0, BUSY}, 4'b0000);

        // Single OR sample, latency DEPTH
        step("t1a", 4'b1100, 4'b1010, 3'd0, 1'b1, 1'b0);
        check("t1_nov", {3'b0, Y_VALID}, 4'b0000);
        step("t1b", 4'b0, 4'b0, 3'd0, 1'b0, 1'b0);
        check("t1_y", Y, 4'b1110);
        check("t1_v", {3'b0, Y_VALID}, 4'b0001);
        step("t1c", 4'b0, 4'b0, 3'd0, 1'b0, 1'b0);
        check("t1_hold", Y, 4'b1110);
        check("t1_pulse", {3'b0, Y_VALID}, 4'b0000);

        // Truth table, each function after its flush
        for (int i = 0; i < 8; i++) begin
            cf = tbl_f[i];
            step("t2chg", 4'b0, 4'b0, cf, 1'b0, 1'b0);
            check("t2_busy", {3'b0, BUSY}, 4'b0001);
            step("t2fl", 4'b0, 4'b0, cf, 1'b0, 1'b0);
            step("t2fl", 4'b0, 4'b0, cf, 1'b0, 1'b0);
            check("t2_run", {3'b0, BUSY}, 4'b0000);
            step("t2s", 4'b1100, 4'b1010, cf, 1'b1, 1'b0);
            step("t2o", 4'b0, 4'b0, cf, 1'b0, 1'b0);
            check($sformatf("t2_f%0d", cf), Y, tbl_y[cf]);
        end

        // Streaming four back-to-back samples
        for (int k = 0; k < 6; k++) begin
            step("t3", (k < 4) ? 4'(1 << k) : 4'b0, 4'b0, 3'd0,
                 (k < 4), 1'b0);
            if (k >= 1 && k <= 4) begin
                check($sformatf("t3_y%0d", k), Y, 4'(1 << (k - 1)));
                check("t3_v", {3'b0, Y_VALID}, 4'b0001);
            end
        end
        check("t3_end", {3'b0, Y_VALID}, 4'b0000);

        // Function change with a result in flight
        step("t4a", 4'b0101, 4'b0, 3'd0, 1'b1, 1'b0);
        step("t4chg", 4'b0011, 4'b0, 3'd1, 1'b1, 1'b0);
        check("t4_hold", Y, 4'b1000);
        check("t4_busy", {3'b0, BUSY}, 4'b0001);
        step("t4b", 4'b1111, 4'b1111, 3'd1, 1'b1, 1'b0);
        check("t4_busy2", {3'b0, BUSY}, 4'b0001);
        step("t4c", 4'b1111, 4'b1111, 3'd1, 1'b1, 1'b0);
        check("t4_run", {3'b0, BUSY}, 4'b0000);
        step("t4d", 4'b0, 4'b0, 3'd1, 1'b0, 1'b0);
        check("t4_nov", {3'b0, Y_VALID}, 4'b0000);
        check("t4_hold2", Y, 4'b1000);

        // Reset just before a pulse
        step("t5s", 4'b1100, 4'b1010, 3'd1, 1'b1, 1'b0);
        step("t5r", 4'b0, 4'b0, 3'd1, 1'b0, 1'b1);
        check("t5_y0", Y, 4'b0000);
        check("t5_nov", {3'b0, Y_VALID}, 4'b0000);
        check("t5_busy", {3'b0, BUSY}, 4'b0000);
        step("t5a", 4'b1100, 4'b1010, 3'd0, 1'b1, 1'b0);
        check("t5_noflush", {3'b0, BUSY}, 4'b0000);
        step("t5b", 4'b0, 4'b0, 3'd0, 1'b0, 1'b0);
        check("t5_y", Y, 4'b1110);
        check("t5_v", {3'b0, Y_VALID}, 4'b0001);

`ifdef GATE_BANK_PIPE_PARITY_EN
        // Parity of an XOR result
        step("t6chg", 4'b0, 4'b0, 3'd4, 1'b0, 1'b0);
        step("t6fl", 4'b0, 4'b0, 3'd4, 1'b0, 1'b0);
        step("t6fl", 4'b0, 4'b0, 3'd4, 1'b0, 1'b0);
        step("t6s", 4'b1111, 4'b0001, 3'd4, 1'b1, 1'b0);
        step("t6o", 4'b0, 4'b0, 3'd4, 1'b0, 1'b0);
        check("t6_y", Y, 4'b1110);
        check("t6_par", {3'b0, Y_PAR}, 4'b0001);
`endif

        // Random traffic against the reference model
        cf = FUNC;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                cf = 3'($urandom_range(0, 7));
            end
            step("rnd", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 cf, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 49) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
